// File: rtl/mig_burst_pkg.sv
// Shared types for the MIG burst engine: FSM states, app_cmd encodings, saturating counter helper.
package mig_burst_pkg;

  typedef enum logic [2:0] {
    CALIB,
    IDLE,
    WRITE,
    READ,
    DONE
  } state_e;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mig_rd_fifo.sv
// Synchronous FIFO with occupancy count; head visible 1 cycle after push.
// Push while full is accepted only together with a pop; pop on empty is ignored.
module mig_rd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/mig_burst_engine.sv
// Burst read/write engine for the MIG app interface; write beats pass through combinationally, reads return via a credit-managed FIFO.
// Optional counters behind MIG_BURST_STATS_EN (stat_wr_beats, stat_rd_beats, stat_stall_cycles).
module mig_burst_engine
  import mig_burst_pkg::*;
#(
  parameter int ADDR_W        = 29,
  parameter int DATA_W        = 256,
  parameter int LEN_W         = 16,
  parameter int ADDR_STRIDE   = 8,
  parameter int RD_FIFO_DEPTH = 16
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  input  logic                init_calib_complete,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                done,
`ifdef MIG_BURST_STATS_EN
  output logic [31:0]         stat_wr_beats,
  output logic [31:0]         stat_rd_beats,
  output logic [31:0]         stat_stall_cycles,
`endif
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   pushed_q, pushed_d;
  logic [CNT_W-1:0]   outst_q, outst_d;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               credit_ok, wr_fire, rd_cmd_en, rd_accept, rd_ret;

  always_comb begin
    // Space is reserved for every in-flight read so returning data can never overflow the FIFO.
    credit_ok = ({1'b0, fifo_count} + {1'b0, outst_q}) < (CNT_W+1)'(RD_FIFO_DEPTH);
    wr_fire   = (state_q == WRITE) && app_rdy && app_wdf_rdy && wr_valid;
    rd_cmd_en = (state_q == READ) && (issued_q != len_q) && credit_ok;
    rd_accept = rd_cmd_en && app_rdy;
    rd_ret    = app_rd_data_valid && (outst_q != '0);

    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    pushed_d = pushed_q;
    outst_d  = outst_q + CNT_W'(rd_accept) - CNT_W'(rd_ret);

    case (state_q)
      CALIB: if (init_calib_complete) state_d = IDLE;
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          len_d    = req_len;
          issued_d = '0;
          pushed_d = '0;
          if (req_len == '0)  state_d = DONE;
          else if (req_write) state_d = WRITE;
          else                state_d = READ;
        end
      end
      WRITE: begin
        if (wr_fire) begin
          addr_d   = addr_q + ADDR_W'(ADDR_STRIDE);
          issued_d = issued_q + LEN_W'(1);
          if (issued_q == len_q - LEN_W'(1)) state_d = DONE;
        end
      end
      READ: begin
        if (rd_accept) begin
          addr_d   = addr_q + ADDR_W'(ADDR_STRIDE);
          issued_d = issued_q + LEN_W'(1);
        end
        if (app_rd_data_valid) begin
          pushed_d = pushed_q + LEN_W'(1);
          if (pushed_q == len_q - LEN_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = CALIB;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q  <= CALIB;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      pushed_q <= '0;
      outst_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      pushed_q <= pushed_d;
      outst_q  <= outst_d;
    end
  end

  mig_rd_fifo #(
    .DEPTH (RD_FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_rd_fifo (
    .clk      (ui_clk),
    .rst      (ui_clk_sync_rst),
    .push     (app_rd_data_valid),
    .push_dat (app_rd_data),
    .pop      (rd_valid && rd_ready),
    .head_dat (rd_data),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rd_valid     = !fifo_empty;
  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q == WRITE) || (state_q == READ) || (state_q == DONE);
  assign done         = (state_q == DONE);
  assign app_addr     = addr_q;
  assign app_cmd      = (state_q == READ) ? CMD_READ : CMD_WRITE;
  assign app_en       = wr_fire || rd_cmd_en;
  assign app_wdf_wren = wr_fire;
  assign app_wdf_end  = wr_fire;
  assign app_wdf_data = wr_data;
  assign app_wdf_mask = '0;
  assign wr_ready     = wr_fire;

`ifdef MIG_BURST_STATS_EN
  logic [31:0] st_wr_q, st_wr_d, st_rd_q, st_rd_d, st_stall_q, st_stall_d;

  always_comb begin
    st_wr_d    = wr_fire   ? sat_inc32(st_wr_q) : st_wr_q;
    st_rd_d    = rd_accept ? sat_inc32(st_rd_q) : st_rd_q;
    st_stall_d = (app_en && !app_rdy) ? sat_inc32(st_stall_q) : st_stall_q;
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      st_wr_q    <= '0;
      st_rd_q    <= '0;
      st_stall_q <= '0;
    end else begin
      st_wr_q    <= st_wr_d;
      st_rd_q    <= st_rd_d;
      st_stall_q <= st_stall_d;
    end
  end

  assign stat_wr_beats     = st_wr_q;
  assign stat_rd_beats     = st_rd_q;
  assign stat_stall_cycles = st_stall_q;
`endif

endmodule

// File: tb/tb_mig_burst_engine.sv
// Self-checking bench for mig_burst_engine: randomized MIG/source/sink environment plus queue-based reference model.
module tb_mig_burst_engine;

  localparam int ADDR_W = 29;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 16;

  logic                ui_clk = 1'b0;
  logic                ui_clk_sync_rst = 1'b1;
  logic                init_calib_complete = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_write = 1'b0;
  logic [ADDR_W-1:0]   req_addr = '0;
  logic [LEN_W-1:0]    req_len = '0;
  logic                wr_valid = 1'b0;
  logic [DATA_W-1:0]   wr_data = '0;
  logic                rd_ready = 1'b0;
  logic                app_rdy = 1'b0;
  logic                app_wdf_rdy = 1'b0;
  logic [DATA_W-1:0]   app_rd_data = '0;
  logic                app_rd_data_valid = 1'b0;

  logic                req_ready, wr_ready, rd_valid, busy, done;
  logic [DATA_W-1:0]   rd_data, app_wdf_data;
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en, app_wdf_wren, app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
`ifdef MIG_BURST_STATS_EN
  logic [31:0]         stat_wr_beats, stat_rd_beats, stat_stall_cycles;
`endif

  mig_burst_engine dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .init_calib_complete (init_calib_complete),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .req_len             (req_len),
    .wr_valid            (wr_valid),
    .wr_ready            (wr_ready),
    .wr_data             (wr_data),
    .rd_valid            (rd_valid),
    .rd_ready            (rd_ready),
    .rd_data             (rd_data),
    .busy                (busy),
    .done                (done),
`ifdef MIG_BURST_STATS_EN
    .stat_wr_beats       (stat_wr_beats),
    .stat_rd_beats       (stat_rd_beats),
    .stat_stall_cycles   (stat_stall_cycles),
`endif
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid)
  );

  initial forever #5 ui_clk = ~ui_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge ui_clk) cyc <= cyc + 1;

  // Environment knobs (written by tests) and logs (written by the environment only).
  int                rdy_pct = 100, src_pct = 100, sink_pct = 100;
  bit                man_rdy_en = 1'b0, man_rdy = 1'b1;
  int                flush_req = 0, flush_ack = 0;
  logic [31:0]       salt = 32'h0;
  logic [DATA_W-1:0] src_data [64];
  int                src_len = 0, src_idx = 0, last_due = 0;
  logic [ADDR_W-1:0] cmd_addr_q [$];
  logic [2:0]        cmd_type_q [$];
  logic [DATA_W-1:0] wdat_q [$];
  logic [DATA_W-1:0] rd_q [$];
  int                done_q [$];
  int                due_q [$];
  logic [ADDR_W-1:0] raddr_q [$];
  int                last_wr_cyc = 0, stall_obs = 0, proto_err = 0;

  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    return {8{({3'b0, a} ^ salt)}};
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] a, input int i);
    return a + ADDR_W'(i * 8);
  endfunction

  // Inputs change on the falling edge; DUT outputs are sampled 2ns later, well away from the rising edge.
  initial begin : env
    forever begin
      @(negedge ui_clk);
      if (flush_ack != flush_req) begin
        flush_ack = flush_req;
        cmd_addr_q.delete(); cmd_type_q.delete(); wdat_q.delete(); rd_q.delete();
        done_q.delete(); due_q.delete(); raddr_q.delete();
        src_idx = 0; last_due = 0; stall_obs = 0; proto_err = 0; last_wr_cyc = 0;
      end
      app_rdy     = man_rdy_en ? man_rdy : ($urandom_range(0, 99) < rdy_pct);
      app_wdf_rdy = man_rdy_en ? man_rdy : ($urandom_range(0, 99) < rdy_pct);
      wr_valid    = (src_idx < src_len) && ($urandom_range(0, 99) < src_pct);
      wr_data     = (src_idx < 64) ? src_data[src_idx] : '0;
      rd_ready    = ($urandom_range(0, 99) < sink_pct);
      app_rd_data_valid = 1'b0;
      app_rd_data       = '0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data       = data_of(raddr_q[0]);
        void'(due_q.pop_front());
        void'(raddr_q.pop_front());
      end
      #2;
      if (app_en && app_rdy) begin
        cmd_addr_q.push_back(app_addr);
        cmd_type_q.push_back(app_cmd);
        if (app_cmd == 3'b001) begin
          last_due = (cyc + int'($urandom_range(1, 4)) > last_due) ? cyc + int'($urandom_range(1, 4)) : last_due;
          due_q.push_back(last_due);
          raddr_q.push_back(app_addr);
        end
      end
      if (app_en && !app_rdy) stall_obs++;
      if ((app_wdf_end !== app_wdf_wren) || (app_wdf_mask !== '0)) proto_err++;
      if (app_wdf_wren && (app_cmd !== 3'b000)) proto_err++;
      if (app_wdf_wren) begin
        wdat_q.push_back(app_wdf_data);
        last_wr_cyc = cyc;
      end
      if (wr_valid && wr_ready) src_idx++;
      if (rd_valid && rd_ready) rd_q.push_back(rd_data);
      if (done) done_q.push_back(cyc);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge ui_clk);
    #3;
  endtask

  task automatic flush();
    flush_req++;
    step();
  endtask

  task automatic send_req(input logic w, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                          output int acc_cyc, output bit ok);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    ok = 1'b0; acc_cyc = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (req_ready) begin
        acc_cyc = cyc;
        ok = 1'b1;
      end
      step();
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (done_q.size() > 0) ok = 1'b1;
    end
  endtask

  task automatic wait_rd(input int n, input int budget, output bit ok);
    ok = (rd_q.size() >= n);
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (rd_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic load_src(input int n);
    for (int i = 0; i < 64; i++)
      src_data[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    src_len = n;
  endtask

  task automatic test_reset();
    ui_clk_sync_rst = 1'b1; init_calib_complete = 1'b0;
    step(); step();
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (app_en !== 1'b0) begin bad++; $display("FAIL rst_app_en: got %b want 0", app_en); end
    total++; if (app_wdf_wren !== 1'b0) begin bad++; $display("FAIL rst_wren: got %b want 0", app_wdf_wren); end
    total++; if (app_addr !== '0) begin bad++; $display("FAIL rst_app_addr: got %h want 0", app_addr); end
    total++; if (app_cmd !== 3'b000) begin bad++; $display("FAIL rst_app_cmd: got %b want 000", app_cmd); end
    ui_clk_sync_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL calib_hold: got req_ready=%b want 0", req_ready); end
    end
    init_calib_complete = 1'b1;
    step();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL calib_exit: got req_ready=%b want 1", req_ready); end
  endtask

  task automatic test_write_basic();
    int acc; bit ok;
    salt = $urandom; rdy_pct = 100; src_pct = 100; sink_pct = 100; man_rdy_en = 1'b0;
    load_src(4); flush();
    send_req(1'b1, 29'h100, 16'd4, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_basic_accept: got no accept want accept"); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_basic_busy: got %b want 1", busy); end
    wait_done(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_basic_done: got timeout want done"); end
    total++; if (cmd_addr_q.size() != 4) begin bad++; $display("FAIL wr_basic_cnt: got %0d want 4", cmd_addr_q.size()); end
    for (int i = 0; i < 4 && i < cmd_addr_q.size() && i < wdat_q.size(); i++) begin
      total++; if (cmd_addr_q[i] !== exp_addr(29'h100, i)) begin bad++; $display("FAIL wr_basic_addr[%0d]: got %h want %h", i, cmd_addr_q[i], exp_addr(29'h100, i)); end
      total++; if (wdat_q[i] !== src_data[i]) begin bad++; $display("FAIL wr_basic_data[%0d]: got %h want %h", i, wdat_q[i], src_data[i]); end
    end
    total++; if (ok && (done_q[0] - last_wr_cyc) != 1) begin bad++; $display("FAIL wr_basic_done_lat: got %0d want 1", done_q[0] - last_wr_cyc); end
    step(); step();
    total++; if (done_q.size() != 1) begin bad++; $display("FAIL wr_basic_done_pulse: got %0d cycles want 1", done_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_basic_idle: got busy=%b want 0", busy); end
    total++; if (proto_err != 0) begin bad++; $display("FAIL wr_basic_proto: got %0d errors want 0", proto_err); end
  endtask

  task automatic test_write_stall();
    int acc, n; bit ok; logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom) & ~ADDR_W'(7);
    salt = $urandom; src_pct = 100; man_rdy_en = 1'b1; man_rdy = 1'b1;
    load_src(6); flush();
    send_req(1'b1, a, 16'd6, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_stall_accept: got no accept want accept"); end
    for (int i = 0; i < 20 && wdat_q.size() < 2; i++) step();
    man_rdy = 1'b0;
    step();
    n = wdat_q.size();
    for (int k = 0; k < 3; k++) begin
      total++; if (app_en !== 1'b0 || wr_ready !== 1'b0) begin bad++; $display("FAIL wr_stall_en[%0d]: got en=%b rdy=%b want 0", k, app_en, wr_ready); end
      total++; if (app_addr !== exp_addr(a, n)) begin bad++; $display("FAIL wr_stall_addr[%0d]: got %h want %h", k, app_addr, exp_addr(a, n)); end
      total++; if (app_wdf_data !== src_data[n]) begin bad++; $display("FAIL wr_stall_data[%0d]: got %h want %h", k, app_wdf_data, src_data[n]); end
      if (k < 2) step();
    end
    man_rdy = 1'b1;
    wait_done(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_stall_done: got timeout want done"); end
    total++; if (wdat_q.size() != 6) begin bad++; $display("FAIL wr_stall_cnt: got %0d want 6", wdat_q.size()); end
    for (int i = 0; i < wdat_q.size() && i < 6; i++) begin
      total++; if (wdat_q[i] !== src_data[i] || cmd_addr_q[i] !== exp_addr(a, i)) begin bad++; $display("FAIL wr_stall_beat[%0d]: got %h@%h want %h@%h", i, wdat_q[i], cmd_addr_q[i], src_data[i], exp_addr(a, i)); end
    end
    man_rdy_en = 1'b0;
  endtask

  task automatic test_write_random();
    int acc, len; bit ok; logic [ADDR_W-1:0] a;
    for (int it = 0; it < 3; it++) begin
      rdy_pct = $urandom_range(30, 100); src_pct = $urandom_range(30, 100);
      len = $urandom_range(1, 20); a = ADDR_W'($urandom) & ~ADDR_W'(7);
      load_src(len); flush();
      send_req(1'b1, a, LEN_W'(len), acc, ok);
      total++; if (!ok) begin bad++; $display("FAIL wr_rand_accept[%0d]: got no accept want accept", it); end
      wait_done(400, ok);
      total++; if (!ok) begin bad++; $display("FAIL wr_rand_done[%0d]: got timeout want done", it); end
      total++; if (wdat_q.size() != len || cmd_addr_q.size() != len) begin bad++; $display("FAIL wr_rand_cnt[%0d]: got %0d/%0d want %0d", it, wdat_q.size(), cmd_addr_q.size(), len); end
      for (int i = 0; i < len && i < wdat_q.size() && i < cmd_addr_q.size(); i++) begin
        total++; if (wdat_q[i] !== src_data[i] || cmd_addr_q[i] !== exp_addr(a, i)) begin bad++; $display("FAIL wr_rand_beat[%0d][%0d]: got %h@%h want %h@%h", it, i, wdat_q[i], cmd_addr_q[i], src_data[i], exp_addr(a, i)); end
      end
      total++; if (proto_err != 0) begin bad++; $display("FAIL wr_rand_proto[%0d]: got %0d want 0", it, proto_err); end
    end
    rdy_pct = 100; src_pct = 100;
  endtask

  task automatic test_read_backpressure();
    int acc; bit ok; logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom) & ~ADDR_W'(7);
    salt = $urandom; rdy_pct = 100; sink_pct = 0;
    load_src(0); flush();
    send_req(1'b0, a, 16'd20, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL rd_bp_accept: got no accept want accept"); end
    for (int i = 0; i < 60; i++) step();
    total++; if (cmd_addr_q.size() != 16) begin bad++; $display("FAIL rd_bp_credit: got %0d cmds want 16", cmd_addr_q.size()); end
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_bp_valid: got %b want 1", rd_valid); end
    total++; if (done_q.size() != 0 || busy !== 1'b1) begin bad++; $display("FAIL rd_bp_busy: got done=%0d busy=%b want 0/1", done_q.size(), busy); end
    sink_pct = 100;
    wait_rd(20, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL rd_bp_drain: got %0d beats want 20", rd_q.size()); end
    total++; if (done_q.size() != 1) begin bad++; $display("FAIL rd_bp_done: got %0d want 1", done_q.size()); end
    total++; if (cmd_addr_q.size() != 20) begin bad++; $display("FAIL rd_bp_cmds: got %0d want 20", cmd_addr_q.size()); end
    for (int i = 0; i < 20 && i < rd_q.size() && i < cmd_addr_q.size(); i++) begin
      total++; if (rd_q[i] !== data_of(exp_addr(a, i)) || cmd_type_q[i] !== 3'b001) begin bad++; $display("FAIL rd_bp_beat[%0d]: got %h cmd %b want %h cmd 001", i, rd_q[i], cmd_type_q[i], data_of(exp_addr(a, i))); end
    end
    step();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_bp_empty: got %b want 0", rd_valid); end
  endtask

  task automatic test_read_random();
    int acc, len; bit ok; logic [ADDR_W-1:0] a;
    for (int it = 0; it < 3; it++) begin
      rdy_pct = $urandom_range(40, 100); sink_pct = $urandom_range(20, 100);
      len = $urandom_range(1, 40); a = ADDR_W'($urandom) & ~ADDR_W'(7); salt = $urandom;
      flush();
      send_req(1'b0, a, LEN_W'(len), acc, ok);
      total++; if (!ok) begin bad++; $display("FAIL rd_rand_accept[%0d]: got no accept want accept", it); end
      wait_done(800, ok);
      total++; if (!ok) begin bad++; $display("FAIL rd_rand_done[%0d]: got timeout want done", it); end
      wait_rd(len, 800, ok);
      total++; if (!ok || cmd_addr_q.size() != len) begin bad++; $display("FAIL rd_rand_cnt[%0d]: got %0d beats %0d cmds want %0d", it, rd_q.size(), cmd_addr_q.size(), len); end
      for (int i = 0; i < len && i < rd_q.size(); i++) begin
        total++; if (rd_q[i] !== data_of(exp_addr(a, i))) begin bad++; $display("FAIL rd_rand_beat[%0d][%0d]: got %h want %h", it, i, rd_q[i], data_of(exp_addr(a, i))); end
      end
    end
    rdy_pct = 100; sink_pct = 100;
  endtask

  task automatic test_boundary();
    int acc; bit ok;
    load_src(2); flush();
    send_req(1'b1, 29'h1FFF_FFF8, 16'd2, acc, ok);
    wait_done(50, ok);
    total++; if (!ok || cmd_addr_q.size() != 2) begin bad++; $display("FAIL wrap_cnt: got %0d cmds want 2", cmd_addr_q.size()); end
    if (cmd_addr_q.size() == 2) begin
      total++; if (cmd_addr_q[0] !== 29'h1FFF_FFF8 || cmd_addr_q[1] !== 29'h0) begin bad++; $display("FAIL wrap_addr: got %h,%h want 1ffffff8,0", cmd_addr_q[0], cmd_addr_q[1]); end
    end
    for (int d = 0; d < 2; d++) begin
      load_src(0); flush();
      send_req(d[0], ADDR_W'($urandom), 16'd0, acc, ok);
      wait_done(10, ok);
      total++; if (!ok || (done_q[0] - acc) != 1) begin bad++; $display("FAIL zero_len_lat[%0d]: got %0d want 1", d, ok ? done_q[0] - acc : -1); end
      step();
      total++; if (cmd_addr_q.size() != 0 || stall_obs != 0) begin bad++; $display("FAIL zero_len_en[%0d]: got %0d cmds want 0", d, cmd_addr_q.size() + stall_obs); end
    end
  endtask

  task automatic test_reset_mid_read();
    int acc; bit ok;
    salt = $urandom; rdy_pct = 100; sink_pct = 0;
    flush();
    send_req(1'b0, 29'h2000, 16'd20, acc, ok);
    for (int i = 0; i < 8; i++) step();
    ui_clk_sync_rst = 1'b1;
    flush_req++;
    step();
    total++; if (req_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_ctl: got rdy=%b busy=%b done=%b want 0", req_ready, busy, done); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_fifo: got rd_valid=%b want 0", rd_valid); end
    total++; if (app_en !== 1'b0 || app_addr !== '0 || app_cmd !== 3'b000) begin bad++; $display("FAIL midrst_app: got en=%b addr=%h cmd=%b want 0", app_en, app_addr, app_cmd); end
    step();
    ui_clk_sync_rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++; if (done_q.size() != 0 || rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_after: got done=%0d rd_valid=%b want 0", done_q.size(), rd_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle: got %b want 1", req_ready); end
    sink_pct = 100; flush();
    send_req(1'b0, 29'h40, 16'd16, acc, ok);
    wait_rd(16, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_recover: got %0d beats want 16", rd_q.size()); end
    for (int i = 0; i < rd_q.size(); i++) begin
      total++; if (rd_q[i] !== data_of(exp_addr(29'h40, i))) begin bad++; $display("FAIL midrst_beat[%0d]: got %h want %h", i, rd_q[i], data_of(exp_addr(29'h40, i))); end
    end
  endtask

  task automatic test_back_to_back();
    int acc; bit ok;
    ui_clk_sync_rst = 1'b1; step(); step(); ui_clk_sync_rst = 1'b0;
    salt = $urandom; rdy_pct = 70; sink_pct = 100; src_pct = 100;
    load_src(4); flush();
    send_req(1'b1, 29'h300, 16'd4, acc, ok);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_wr_done: got timeout want done"); end
    send_req(1'b0, 29'h300, 16'd6, acc, ok);
    wait_rd(6, 300, ok);
    step(); step();
    total++; if (!ok || done_q.size() != 2) begin bad++; $display("FAIL b2b_done: got %0d dones want 2", done_q.size()); end
    total++; if (cmd_addr_q.size() != 10) begin bad++; $display("FAIL b2b_cmds: got %0d want 10", cmd_addr_q.size()); end
    for (int i = 0; i < rd_q.size() && i < 6; i++) begin
      total++; if (rd_q[i] !== data_of(exp_addr(29'h300, i))) begin bad++; $display("FAIL b2b_rd[%0d]: got %h want %h", i, rd_q[i], data_of(exp_addr(29'h300, i))); end
    end
`ifdef MIG_BURST_STATS_EN
    total++; if (stat_wr_beats !== 32'd4) begin bad++; $display("FAIL stat_wr: got %0d want 4", stat_wr_beats); end
    total++; if (stat_rd_beats !== 32'd6) begin bad++; $display("FAIL stat_rd: got %0d want 6", stat_rd_beats); end
    total++; if (stat_stall_cycles !== 32'(stall_obs)) begin bad++; $display("FAIL stat_stall: got %0d want %0d", stat_stall_cycles, stall_obs); end
`endif
    rdy_pct = 100;
  endtask

  initial begin : main
    test_reset();
    test_write_basic();
    test_write_stall();
    test_write_random();
    test_read_backpressure();
    test_read_random();
    test_boundary();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
